// File: rtl/bus_demux_buffer_if.sv
// Bus-side and consumer-side signals of the two-channel demultiplexing buffer.
// The slave modport is the buffer's view; master is the bus driver / consumers.
interface bus_demux_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             q1_valid;
    logic             q1_ready;
    logic [WIDTH-1:0] q1_data;
    logic [CW-1:0]    q1_count;
    logic             q2_valid;
    logic             q2_ready;
    logic [WIDTH-1:0] q2_data;
    logic [CW-1:0]    q2_count;

    modport slave (
        input  in_valid, in_data, in_sel, q1_ready, q2_ready,
        output in_ready, q1_valid, q1_data, q1_count, q2_valid, q2_data, q2_count
    );

    modport master (
        output in_valid, in_data, in_sel, q1_ready, q2_ready,
        input  in_ready, q1_valid, q1_data, q1_count, q2_valid, q2_data, q2_count
    );
endinterface

// File: rtl/bus_demux_buffer.sv
// Steers each bus word to one of two FIFO-buffered channels (sel=0 -> ch1, sel=1 -> ch2).
// Per-channel occupancy count is the only full/empty indicator; pointers wrap naturally.
module bus_demux_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    bus_demux_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [PW-1:0]    wr1, rd1, wr2, rd2;
    logic [CW-1:0]    cnt1, cnt2;
    logic             push1, push2, pop1, pop2;
    logic             rdy;

    // Readiness looks only at the selected channel's occupancy, so a full channel
    // never blocks the other and a same-cycle pop never frees a slot early.
    always_comb begin
        rdy   = bus.in_sel ? (cnt2 != FULL) : (cnt1 != FULL);
        push1 = bus.in_valid && rdy && !bus.in_sel;
        push2 = bus.in_valid && rdy &&  bus.in_sel;
        pop1  = (cnt1 != '0) && bus.q1_ready;
        pop2  = (cnt2 != '0) && bus.q2_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr1  <= '0;
            rd1  <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) wr1 <= wr1 + PW'(1);
            if (pop1)  rd1 <= rd1 + PW'(1);
            if (push1 && !pop1)      cnt1 <= cnt1 + CW'(1);
            else if (pop1 && !push1) cnt1 <= cnt1 - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr2  <= '0;
            rd2  <= '0;
            cnt2 <= '0;
        end else begin
            if (push2) wr2 <= wr2 + PW'(1);
            if (pop2)  rd2 <= rd2 + PW'(1);
            if (push2 && !pop2)      cnt2 <= cnt2 + CW'(1);
            else if (pop2 && !push2) cnt2 <= cnt2 - CW'(1);
        end
    end

    // Storage is deliberately not reset; the zero count masks stale entries.
    always_ff @(posedge clk) begin
        if (push1) mem1[wr1] <= bus.in_data;
        if (push2) mem2[wr2] <= bus.in_data;
    end

    always_comb begin
        bus.in_ready = rdy;
        bus.q1_valid = (cnt1 != '0);
        bus.q2_valid = (cnt2 != '0);
        bus.q1_data  = (cnt1 != '0) ? mem1[rd1] : '0;
        bus.q2_data  = (cnt2 != '0) ? mem2[rd2] : '0;
        bus.q1_count = cnt1;
        bus.q2_count = cnt2;
    end
endmodule

// File: tb/tb_bus_demux_buffer.sv
// Randomised and directed checks of bus_demux_buffer against a queue-based model.
module tb_bus_demux_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_demux_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bus_demux_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] q1m [$];
    logic [WIDTH-1:0] q2m [$];
    logic [WIDTH-1:0] rx1 [$];
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit last_push1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a bounded queue per channel; pops come from the head, pushes go to the tail.
    task automatic model_edge();
        int n1, n2;
        bit acc, p1, p2;
        if (!rst_n) begin
            q1m.delete();
            q2m.delete();
            last_push1 = 1'b0;
            return;
        end
        n1 = q1m.size();
        n2 = q2m.size();
        acc = bus.in_valid && ((bus.in_sel ? n2 : n1) != DEPTH);
        p1 = bus.q1_ready && n1 != 0;
        p2 = bus.q2_ready && n2 != 0;
        if (p1) rx1.push_back(q1m.pop_front());
        if (p2) void'(q2m.pop_front());
        if (acc && !bus.in_sel) q1m.push_back(bus.in_data);
        if (acc &&  bus.in_sel) q2m.push_back(bus.in_data);
        last_push1 = acc && !bus.in_sel;
    endtask

    task automatic step(input bit v, input bit s, input logic [WIDTH-1:0] d,
                        input bit r1, input bit r2);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.q1_ready = r1;
        bus.q2_ready = r2;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q1_valid", 32'(bus.q1_valid), 32'(q1m.size() != 0));
            chk("q2_valid", 32'(bus.q2_valid), 32'(q2m.size() != 0));
            chk("q1_data", 32'(bus.q1_data), q1m.size() != 0 ? 32'(q1m[0]) : 32'h0);
            chk("q2_data", 32'(bus.q2_data), q2m.size() != 0 ? 32'(q2m[0]) : 32'h0);
            chk("q1_count", 32'(bus.q1_count), 32'(q1m.size()));
            chk("q2_count", 32'(bus.q2_count), 32'(q2m.size()));
            chk("in_ready", 32'(bus.in_ready),
                32'((bus.in_sel ? q2m.size() : q1m.size()) != DEPTH));
        end
    end

    initial begin
        int k;
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.q1_ready = 1'b0;
        bus.q2_ready = 1'b0;
        chk_en = 1'b1;

        // Reset then idle
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        chk("rst q1_valid", 32'(bus.q1_valid), 32'h0);
        chk("rst q2_data", 32'(bus.q2_data), 32'h0);
        chk("rst q1_count", 32'(bus.q1_count), 32'h0);
        bus.in_sel = 1'b1;
        #1 chk("rst in_ready sel1", 32'(bus.in_ready), 32'h1);
        bus.in_sel = 1'b0;
        #1 chk("rst in_ready sel0", 32'(bus.in_ready), 32'h1);

        // Basic steer
        step(1, 0, 8'hA5, 0, 0);
        chk("steer q1_data", 32'(bus.q1_data), 32'hA5);
        chk("steer q1_count", 32'(bus.q1_count), 32'h1);
        chk("steer q2_valid early", 32'(bus.q2_valid), 32'h0);
        step(1, 1, 8'h3C, 0, 0);
        chk("steer q2_data", 32'(bus.q2_data), 32'h3C);
        chk("steer q2_count", 32'(bus.q2_count), 32'h1);
        chk("steer q1 held", 32'(bus.q1_data), 32'hA5);
        step(0, 0, 8'h00, 1, 1);

        // Full / backpressure
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        chk("full q1_count", 32'(bus.q1_count), 32'h2);
        chk("full in_ready sel0", 32'(bus.in_ready), 32'h0);
        bus.in_sel = 1'b1;
        #1 chk("full in_ready sel1", 32'(bus.in_ready), 32'h1);
        step(1, 1, 8'h77, 0, 0);
        chk("other ch q2_data", 32'(bus.q2_data), 32'h77);
        chk("other ch q1_count", 32'(bus.q1_count), 32'h2);
        chk("other ch q1_data", 32'(bus.q1_data), 32'h11);

        // Full with simultaneous pop: the push must wait one edge
        step(1, 0, 8'h33, 1, 0);
        chk("fullpop q1_count", 32'(bus.q1_count), 32'h1);
        chk("fullpop q1_data", 32'(bus.q1_data), 32'h22);
        step(1, 0, 8'h33, 0, 0);
        chk("fullpop accept count", 32'(bus.q1_count), 32'h2);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 1, 1);

        // Wrap-around and order with toggling consumer
        rx1.delete();
        k = 1;
        for (int cyc = 0; cyc < 40 && k <= 8; cyc++) begin
            step(1, 0, 8'(k), cyc[0] == 1'b0, 0);
            if (last_push1) k++;
            chk("wrap count bound", 32'(bus.q1_count <= 2), 32'h1);
        end
        if (k <= 8) chk("wrap stream timeout", 32'(k), 32'd9);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        chk("wrap rx size", 32'(rx1.size()), 32'd8);
        for (int i = 0; i < rx1.size() && i < 8; i++)
            chk("wrap rx order", 32'(rx1[i]), 32'(i + 1));

        // Reset mid-operation, asserted between edges
        step(1, 0, 8'hC1, 0, 0);
        step(1, 0, 8'hC2, 0, 0);
        step(1, 1, 8'hD1, 0, 0);
        #2 rst_n = 1'b0;
        q1m.delete();
        q2m.delete();
        #1;
        chk("async rst q1_valid", 32'(bus.q1_valid), 32'h0);
        chk("async rst q2_valid", 32'(bus.q2_valid), 32'h0);
        step(0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        chk("post rst q1_count", 32'(bus.q1_count), 32'h0);
        step(1, 1, 8'h5A, 0, 0);
        chk("post rst q2 head", 32'(bus.q2_data), 32'h5A);
        chk("post rst q1_data", 32'(bus.q1_data), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
